adc_frame_scheduler: RTL
========================

# adc_frame_scheduler

Sequences the eight per-channel I2S ADC receivers into the 128-bit AXI-Stream sink. Each cycle it grants at most one pending receiver, acknowledges it, and captures its 24-bit sample into a frame buffer. Once all eight slots are filled, or a partial frame times out, it emits the frame as two AXIS beats with `tlast` on the second. It sits between the receivers' ready/ack flag pairs and the AXIS output of `wrapper`.

## Interface
- `SAMPLE_W`, 24, receiver sample width in bits (must be ≤ 32).
- `FRAME_TIMEOUT`, 128, sck cycles allowed from first capture to frame completion before a partial frame is forced out.
- `CNT_W`, 16, width of `frame_count`.

- `sck`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  enables capture; sampled at frame boundaries.
- `ch_valid`  in  8  per-receiver "sample ready" (flag_adc_to_mux); level, held until acked.
- `ch_data`  in  8*SAMPLE_W  channel i sample at `[i*SAMPLE_W +: SAMPLE_W]`; stable while `ch_valid[i]`.
- `ch_ack`  out  8  per-receiver acknowledge (flag_mux_to_adc); one-cycle pulse, registered.
- `S_AXIS_tdata`  out  128  four 32-bit lanes; lane k at `[32k +: 32]`.
- `S_AXIS_tvalid`  out  1  beat valid.
- `S_AXIS_tready`  in  1  sink ready.
- `S_AXIS_tlast`  out  1  high on the second beat of each frame.
- `frame_count`  out  CNT_W  completed frames; wraps modulo 2^CNT_W.
- `missing`  out  1  sticky; set when a frame is forced out by timeout.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **States:** IDLE, COLLECT, SEND0, SEND1.
- **IDLE:** no captures, `ch_ack` = 0. Moves to COLLECT when `start` = 1.
- **COLLECT capture:**
  - Each cycle, choose the lowest index i with `ch_valid[i]` = 1 and `captured[i]` = 0.
  - Write its sample, extended to 32 bits, into `slot[i]`, and set `captured[i]`.
  - Pulse `ch_ack[i]` in the next cycle. At most one capture per cycle.
- **COLLECT timer:**
  - A timeout counter clears and starts on the first capture of a frame.
  - Go to SEND0 when `captured` = 8'hFF.
  - Also go to SEND0 when the counter reaches FRAME_TIMEOUT−1. In that case, empty slots read 32'h0 and `missing` is set.
- **SEND0:** beat0 = {slot3, slot2, slot1, slot0}, `tlast` = 0. Goes to SEND1 on handshake.
- **SEND1:** beat1 = {slot7, slot6, slot5, slot4}, `tlast` = 1. On handshake:
  - `frame_count` increments.
  - `captured`, the timer, and all slots clear.
  - Next state is COLLECT if `start` = 1, else IDLE.
- **No capture outside COLLECT.** Receivers asserting `ch_valid` during SEND0/SEND1/IDLE wait, unacked.
- **`start` falling mid-frame:** the current frame still completes, including the timeout path; the block then returns to IDLE.
- **Width:** sample bits occupy `[SAMPLE_W-1:0]` of each lane. Upper bits follow the Configuration section.

## Timing
- **Reset values:** `rst` = 1 at an edge clears all state. After that edge:
  - `ch_ack` = 0, `S_AXIS_tvalid` = 0, `S_AXIS_tlast` = 0, `S_AXIS_tdata` = 0
  - `frame_count` = 0, `missing` = 0, `busy` = 0, state = IDLE.
- **Reset mid-operation:** applies from any state, including mid-beat with `tvalid` high. The partial frame is discarded and not emitted.
- **Ack timing:** `ch_valid[i]` sampled high at edge N gives capture at N and `ch_ack[i]` high during cycle N+1 only. Because `captured[i]` is already set, a valid still held at N+1 is not recaptured.
- **Latency:** all 8 valid at edge N gives the last capture at N+7, SEND0 entered at N+8, and `tvalid` high during cycle N+8.
- **Back-to-back frames:** with `tready` = 1, beat1 is in cycle N+9, and COLLECT resumes from N+10.
- **AXIS handshake:** a transfer occurs when `tvalid && tready` at an edge. While `tvalid` = 1 and `tready` = 0, `tdata`, `tlast` and `tvalid` hold stable.
- **Timeout boundary:** a capture that completes the mask on the same edge the timer hits FRAME_TIMEOUT−1 counts as a full frame; `missing` is not set.
- **`frame_count` wrap:** 2^CNT_W−1 wraps to 0 with no flag.

## Configuration
- **Macro:** `ADC_SCHED_SIGN_EXT_EN`.
- **Defined:** lane upper bits are `sample[SAMPLE_W-1]` (two's-complement sign extension).
- **Undefined:** lane upper bits are zero.

## Test plan
1. **Full frame:** `ch_data` = AAAAAA, BBBBBB, CCCCCC, DDDDDD, EEEEEE, FFFFFF, 111111, 222222 (ch0..7), all valid, `tready` = 1, macro defined. Required response:
   - `ch_ack` pulses bits 0..7 on successive cycles.
   - beat0 = FFDDDDDD_FFCCCCCC_FFBBBBBB_FFAAAAAA.
   - beat1 = 00222222_00111111_FFFFFFFF_FFEEEEEE with `tlast` = 1.
   - `frame_count` = 1.
2. **Backpressure:** as 1, with `tready` = 0 for 20 cycles after `tvalid` rises. Beat0 is held constant for 20 cycles, no `ch_ack` pulses occur, and both beats then complete in consecutive cycles.
3. **Timeout:** only ch0..5 valid → SEND0 exactly FRAME_TIMEOUT cycles after the first capture; lanes 6 and 7 = 0; `missing` = 1 and stays set afterwards.
4. **Reset mid-SEND1:** `rst` high for one edge while beat1 is stalled → next cycle `tvalid` = 0, `frame_count` = 0, `busy` = 0, and no beat1 is transferred afterwards.
5. **Start drop:** `start` falls after the third capture → the frame completes and is emitted, then IDLE; valid held on every channel gets no further `ch_ack`.
6. **Macro undefined:** ch0 = AAAAAA → lane0 = 00AAAAAA.

Source files
------------

// File: rtl/adc_frame_scheduler_if.sv
// adc_frame_scheduler_if: 128-bit AXI-Stream beat bundle.
// master drives data/valid/last, slave returns ready.
interface adc_frame_scheduler_if;
  logic [127:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler: grants pending I2S receivers, packs 8 samples into
// two 128-bit AXIS beats. Option ADC_SCHED_SIGN_EXT_EN sign-extends lanes.
module adc_frame_scheduler #(
  parameter int SAMPLE_W      = 24,
  parameter int FRAME_TIMEOUT = 128,
  parameter int CNT_W         = 16
) (
  input  logic                  sck,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            ch_valid,
  input  logic [8*SAMPLE_W-1:0] ch_data,
  output logic [7:0]            ch_ack,
  adc_frame_scheduler_if.master S_AXIS,
  output logic [CNT_W-1:0]      frame_count,
  output logic                  missing,
  output logic                  busy
);

  localparam int TW = $clog2(FRAME_TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(FRAME_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, SEND0, SEND1} state_t;

  state_t        state;
  logic [7:0]    captured;
  logic [31:0]   slot [8];
  logic [TW-1:0] timer;
  logic          running;

  logic [7:0]    pend;
  logic [7:0]    cap;
  logic [7:0]    cap_mask;
  logic [31:0]   slot_nxt [8];
  logic [TW-1:0] timer_nxt;
  logic          run_nxt;
  logic          full;
  logic          expire;

  function automatic logic [31:0] widen(input logic [SAMPLE_W-1:0] s);
    logic [31:0] r;
    r = '0;
    r[SAMPLE_W-1:0] = s;
`ifdef ADC_SCHED_SIGN_EXT_EN
    for (int b = SAMPLE_W; b < 32; b++) r[b] = s[SAMPLE_W-1];
`endif
    return r;
  endfunction

  // Lowest-index pending grant plus the frame state it would produce.
  always_comb begin
    pend     = ch_valid & ~captured;
    cap      = (state == COLLECT) ? (pend & (~pend + 8'd1)) : 8'd0;
    cap_mask = captured | cap;
    run_nxt  = running | (|cap);
    if (running) timer_nxt = timer + TW'(1);
    else         timer_nxt = '0;
    full     = (cap_mask == 8'hFF);
    expire   = run_nxt && (timer_nxt == T_LAST);
    for (int i = 0; i < 8; i++) begin
      slot_nxt[i] = cap[i] ? widen(ch_data[i*SAMPLE_W +: SAMPLE_W])
                           : slot[i];
    end
  end

  // Frame FSM with registered handshake and status outputs.
  always_ff @(posedge sck) begin
    if (rst) begin
      state         <= IDLE;
      captured      <= '0;
      timer         <= '0;
      running       <= 1'b0;
      ch_ack        <= '0;
      S_AXIS.tdata  <= '0;
      S_AXIS.tvalid <= 1'b0;
      S_AXIS.tlast  <= 1'b0;
      frame_count   <= '0;
      missing       <= 1'b0;
      busy          <= 1'b0;
      for (int i = 0; i < 8; i++) slot[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          ch_ack <= '0;
          if (start) begin
            state <= COLLECT;
            busy  <= 1'b1;
          end
        end
        COLLECT: begin
          ch_ack   <= cap;
          captured <= cap_mask;
          timer    <= timer_nxt;
          running  <= run_nxt;
          for (int i = 0; i < 8; i++) slot[i] <= slot_nxt[i];
          if (full || expire) begin
            state         <= SEND0;
            S_AXIS.tvalid <= 1'b1;
            S_AXIS.tlast  <= 1'b0;
            S_AXIS.tdata  <= {slot_nxt[3], slot_nxt[2],
                              slot_nxt[1], slot_nxt[0]};
            if (!full) missing <= 1'b1;
          end
        end
        SEND0: begin
          ch_ack <= '0;
          if (S_AXIS.tready) begin
            state        <= SEND1;
            S_AXIS.tlast <= 1'b1;
            S_AXIS.tdata <= {slot[7], slot[6], slot[5], slot[4]};
          end
        end
        SEND1: begin
          ch_ack <= '0;
          if (S_AXIS.tready) begin
            S_AXIS.tvalid <= 1'b0;
            S_AXIS.tlast  <= 1'b0;
            S_AXIS.tdata  <= '0;
            frame_count   <= frame_count + CNT_W'(1);
            captured      <= '0;
            timer         <= '0;
            running       <= 1'b0;
            for (int i = 0; i < 8; i++) slot[i] <= '0;
            state <= start ? COLLECT : IDLE;
            busy  <= start;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
